// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared RV32I/RV64I types for the EX->MEM boundary: control word, funct3 encodings,
// access size and the boundary's occupancy states.
package ex_mem_pipe_reg_pkg;

  typedef enum logic [2:0] {
    LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011,
    LBU = 3'b100, LHU = 3'b101, LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000, SH = 3'b001, SW = 3'b010, SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
  } rv32i_control_word;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} pipe_state_t;

  function automatic mem_size_t f3_size(input logic [2:0] f3);
    return mem_size_t'(f3[1:0]);
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_mem_lane_align.sv
// Byte-lane alignment: access size + low address bits -> byte masks, lane-shifted
// store data and natural-alignment check. Purely combinational.
module mem_lane_align
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int MASK_W = XLEN / 8,
  localparam int OFF_W  = $clog2(MASK_W)
) (
  input  mem_size_t          size_i,
  input  logic [2:0]         addr_lo_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [XLEN-1:0]    wdata_i,
  output logic [XLEN-1:0]    wdata_o,
  output logic [MASK_W-1:0]  wmask_o,
  output logic [MASK_W-1:0]  rmask_o,
  output logic               misalign_o
);

  logic [7:0]        ones;
  logic [OFF_W-1:0]  off;
  logic [MASK_W-1:0] base;
  logic              mis_raw;

  always_comb begin
    off = addr_lo_i[OFF_W-1:0];
    case (size_i)
      SZ_B:    begin ones = 8'h01; mis_raw = 1'b0;              end
      SZ_H:    begin ones = 8'h03; mis_raw = addr_lo_i[0];      end
      SZ_W:    begin ones = 8'h0F; mis_raw = |addr_lo_i[1:0];   end
      // dword has no legal alignment on a 32-bit datapath
      default: begin ones = 8'hFF; mis_raw = (XLEN == 32) ? 1'b1 : |addr_lo_i; end
    endcase
    base       = MASK_W'(16'(ones) << off);
    misalign_o = mis_raw && (mem_read_i || mem_write_i);
    wmask_o    = (mem_write_i && !misalign_o) ? base : '0;
    rmask_o    = (mem_read_i  && !misalign_o) ? base : '0;
    wdata_o    = wdata_i << {off, 3'b000};
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline boundary with valid/ready on both sides, optional 2-entry skid
// buffer, flush, and lane decode registered with the payload.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  bit SKID_EN = 1'b1,
  localparam int MASK_W  = XLEN / 8,
  localparam int OFF_W   = $clog2(MASK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  rv32i_control_word ctrl_in,
  input  logic [4:0]        rd_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic              br_en_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic [XLEN-1:0]   u_imm_in,
  output logic              mem_valid,
  input  logic              mem_ready,
  output rv32i_control_word ctrl_out,
  output logic [4:0]        rd_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   addr_out,
  output logic [OFF_W-1:0]  byte_off,
  output logic              br_en_out,
  output logic [XLEN-1:0]   wdata_out,
  output logic [MASK_W-1:0] wmask_out,
  output logic [MASK_W-1:0] rmask_out,
  output logic              misalign_out,
  output logic [XLEN-1:0]   u_imm_out
);

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [4:0]        rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   addr;
    logic [OFF_W-1:0]  byte_off;
    logic              br_en;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
    logic [MASK_W-1:0] rmask;
    logic              misalign;
    logic [XLEN-1:0]   u_imm;
  } ex_mem_payload_t;

  pipe_state_t     state_q, state_d;
  ex_mem_payload_t head_q, head_d, skid_q, skid_d, in_pl;
  logic            rdy_en_q;
  logic            acc, drn;
  logic [XLEN-1:0]   al_wdata;
  logic [MASK_W-1:0] al_wmask, al_rmask;
  logic              al_mis;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size_i      (f3_size(ctrl_in.funct3)),
    .addr_lo_i   (addr_in[2:0]),
    .mem_read_i  (ctrl_in.mem_read),
    .mem_write_i (ctrl_in.mem_write),
    .wdata_i     (wdata_in),
    .wdata_o     (al_wdata),
    .wmask_o     (al_wmask),
    .rmask_o     (al_rmask),
    .misalign_o  (al_mis)
  );

  always_comb begin
    in_pl.ctrl     = ctrl_in;
    in_pl.rd       = rd_in;
    in_pl.pc       = pc_in;
    in_pl.addr     = {addr_in[XLEN-1:OFF_W], OFF_W'(0)};
    in_pl.byte_off = addr_in[OFF_W-1:0];
    in_pl.br_en    = br_en_in;
    in_pl.wdata    = al_wdata;
    in_pl.wmask    = al_wmask;
    in_pl.rmask    = al_rmask;
    in_pl.misalign = al_mis;
    in_pl.u_imm    = u_imm_in;
  end

  assign mem_valid = (state_q != ST_EMPTY);

  // rdy_en_q keeps ex_ready low through reset and for the release cycle
  generate
    if (SKID_EN) begin : g_skid
      assign ex_ready = rdy_en_q && (state_q != ST_TWO);
    end else begin : g_single
      assign ex_ready = rdy_en_q && (!mem_valid || mem_ready);
    end
  endgenerate

  assign acc = ex_valid && ex_ready && !flush;
  assign drn = mem_valid && mem_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (acc) begin state_d = ST_ONE; head_d = in_pl; end
      ST_ONE: begin
        if (acc && !drn)      begin state_d = ST_TWO; skid_d = in_pl; end
        else if (acc && drn)  head_d = in_pl;
        else if (drn)         state_d = ST_EMPTY;
      end
      ST_TWO: if (drn) begin state_d = ST_ONE; head_d = skid_q; end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign ctrl_out     = head_q.ctrl;
  assign rd_out       = head_q.rd;
  assign pc_out       = head_q.pc;
  assign addr_out     = head_q.addr;
  assign byte_off     = head_q.byte_off;
  assign br_en_out    = head_q.br_en;
  assign wdata_out    = head_q.wdata;
  assign wmask_out    = head_q.wmask;
  assign rmask_out    = head_q.rmask;
  assign misalign_out = head_q.misalign;
  assign u_imm_out    = head_q.u_imm;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline boundary that replaces the plain load-enabled EX/MEM register. Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so MEM back-pressure does not combinationally reach EX. Adds flush, store-data lane alignment, read/write byte masks for all widths, and misalignment detection. Sits between the EX-stage ALU/branch logic and the data-cache request port.

Parameters:
XLEN, 32, datapath/address width; must be 32 or 64.
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single entry with ex_ready = !mem_valid || mem_ready (combinational).
MASK_W, XLEN/8, byte-lane count; derived, not overridable.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
flush  in  1  kill all held entries and the incoming beat
ex_valid  in  1  EX presents a beat
ex_ready  out  1  boundary can accept a beat
ctrl_in  in  rv32i_control_word  EX control word; uses funct3, mem_read, mem_write
rd_in  in  5  destination register
pc_in  in  XLEN  instruction PC
addr_in  in  XLEN  ALU result / effective address
br_en_in  in  1  branch compare result
wdata_in  in  XLEN  rs2 store data, unaligned
u_imm_in  in  XLEN  U-type immediate
mem_valid  out  1  head entry valid
mem_ready  in  1  MEM consumes head entry
ctrl_out  out  rv32i_control_word  head control word
rd_out  out  5  head rd
pc_out  out  XLEN  head PC
addr_out  out  XLEN  address with low log2(MASK_W) bits cleared
byte_off  out  log2(MASK_W)  original low address bits
br_en_out  out  1  head br_en
wdata_out  out  XLEN  store data shifted left by byte_off*8
wmask_out  out  MASK_W  write byte enables; 0 unless mem_write and aligned
rmask_out  out  MASK_W  read byte enables; 0 unless mem_read and aligned
misalign_out  out  1  access not naturally aligned
u_imm_out  out  XLEN  head U-immediate

Behaviour:
- Reset (rst==0 at a clock edge): state EMPTY. Every output is 0, including ex_ready, mem_valid and all payload outputs. ex_ready rises the cycle after rst deasserts.
- Accept = ex_valid && ex_ready. Drain = mem_valid && mem_ready.
- States (SKID_EN=1): EMPTY, ONE (head valid), TWO (head + skid valid).
- ex_ready = (state != TWO). It is a function of registered state only; no path from mem_ready.
- Transitions:
  - EMPTY: on accept → ONE, beat written to head.
  - ONE: accept with no drain → TWO, beat written to skid. Accept with drain → ONE, beat written to head. Drain only → EMPTY.
  - TWO: drain → ONE, skid moves to head. No accept is possible in TWO.
- Payload is held stable while mem_valid && !mem_ready. Outputs change only on a drain or on a fill into EMPTY.
- Flush has priority over accept and drain: → EMPTY next cycle and the incoming beat is dropped. A drain in the flush cycle is still seen downstream, because mem_ready is sampled combinationally by MEM.
- Decode, computed on entry from addr_in/ctrl_in and registered with the payload (no decode on the output path):
  - size = funct3[1:0]: 0 byte, 1 half, 2 word, 3 dword (dword valid only when XLEN=64; treated as misaligned at XLEN=32).
  - misalign = (mem_read || mem_write) && (addr_in mod 2^size != 0).
  - base = (2^(2^size) - 1) << byte_off, truncated to MASK_W.
  - wmask = (mem_write && !misalign) ? base : 0.
  - rmask = (mem_read && !misalign) ? base : 0.
  - wdata_out = wdata_in << (8*byte_off), truncated to XLEN.
- No memory op: both masks 0, misalign 0, payload passes through unchanged.
- SKID_EN=0: states EMPTY/ONE only; ex_ready combinational as stated under Parameters; everything else identical.

Decomposition:
- Add to rv32i_types: store_funct3/load_funct3 enums (already present) and a new mem_size_t enum {SZ_B, SZ_H, SZ_W, SZ_D}.
- Add a typedef ex_mem_payload_t struct, so head and skid are single registers.
- One sub-module, mem_lane_align: combinational size/offset → mask, shifted data and misalign. Instantiated once on the input side; reusable by the MEM-stage load extractor.

Test Plan:
- Reset then fill: rst=0 for 2 cycles, then 1. Check all outputs 0 during reset and ex_ready=1 one cycle after release. Send sw with addr 0x1000_0004, wdata 0xDEADBEEF, mem_ready=1 → next cycle mem_valid=1, addr_out 0x1000_0004, wmask 4'b1111, wdata_out 0xDEADBEEF.
- Lane alignment: sb to addr 0x…03, wdata 0x0000_00A5 → wmask 4'b1000, wdata_out 0xA500_0000. sh to addr 0x…02 → wmask 4'b1100. lhu from 0x…02 → rmask 4'b1100, wmask 0.
- Misalign: sh to 0x…01 → misalign_out=1, wmask 0. lw from 0x…02 → misalign_out=1, rmask 0.
- Back-pressure: hold mem_ready=0 and send 3 beats (pc 0x10, 0x14, 0x18) → ex_ready falls after the 2nd beat and the 3rd is held by EX. Raise mem_ready → pc_out sequence is 0x10, 0x14, 0x18 with no loss or duplication; output payload stable while stalled.
- Flush in TWO state with ex_valid=1 → next cycle mem_valid=0, ex_ready=1, state EMPTY; the flushed beats never appear at the outputs.
- Reset mid-operation: state TWO, then rst=0 for one edge → all outputs 0 and the held beats are discarded. Run the same sequence at XLEN=64: sd to 0x…08 → wmask 8'hFF; sw to 0x…04 → wmask 8'hF0.
